hex_scan_driver: RTL and testbench
==================================

// Module: hex_scan_driver
// PURPOSE
//  Parametrised time-multiplexed 7-segment driver for the board display: scans DIGITS
//  digits, decodes one 4-bit nibble per digit to active-low segments, double-buffers its
//  input so a frame never shows mixed old/new data, and blanks between slots against ghosting.
//  Sits between the datapath (nibble bus + load strobe) and the pins hex/hex_on.
// PARAMETERS
//  DIGITS     8       number of digits scanned, >=2; index width $clog2(DIGITS)
//  SCAN_DIV   100000  clk cycles per digit slot, >=2
//  BLANK_CYC  2       cycles at slot start with all anodes off, 0 <= BLANK_CYC < SCAN_DIV
//  BLINK_FRM  64      frames per blink half-period (HEX_BLINK_EN only), >=1
// PORTS
//  clk        in   1          system clock, single clock domain
//  rst        in   1          asynchronous active-high reset
//  data       in   4*DIGITS   nibble i = data[4i+3:4i] for digit i
//  dig_en     in   DIGITS     digit i shown when 1, dark when 0
//  load       in   1          1-cycle strobe: capture data/dig_en(/blink) into pending buffer
//  blink      in   DIGITS     per-digit blink mask (present only with HEX_BLINK_EN)
//  hex        out  7          segments, active-low, hex[6:0] = g,f,e,d,c,b,a
//  hex_on     out  DIGITS     anodes, active-low one-hot; bit i drives digit i
//  frame_done out  1          1-cycle pulse when slot DIGITS-1 ends (frame boundary)
// BEHAVIOUR
//  - Reset (async assert, sync release): prescaler=0, idx=0, pending/active buffers=0,
//    hex=7'h7F, hex_on=all 1, frame_done=0. First clk edge after release counts cycle 0.
//  - Prescaler counts 0..SCAN_DIV-1; at SCAN_DIV-1 idx <= (idx==DIGITS-1)?0:idx+1.
//    Wrap DIGITS-1->0 is the frame boundary; frame_done=1 for exactly that cycle
//    (registered, asserted in the cycle prescaler wraps with idx==DIGITS-1).
//  - load: pending <= {data,dig_en(,blink)}; load is ignored otherwise, no handshake/backpressure.
//  - At frame boundary active <= pending. If load and boundary coincide, active <= inputs
//    directly (bypass) and pending <= inputs. Loads mid-frame never alter current frame.
//  - hex, hex_on registered; they reflect (idx, prescaler) of the previous cycle (latency 1).
//  - hex_on[i]=0 iff i==idx, prescaler>=BLANK_CYC, active dig_en[i]=1 (and not blink-blanked);
//    otherwise all 1. hex=7'h7F whenever hex_on is all 1; else decode(active nibble idx).
//  - Decode (hex, hex values): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//    8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
//  - DIGITS not a power of two: idx never exceeds DIGITS-1; unused codes unreachable.
//  - Reset mid-slot/mid-frame: outputs blank immediately (async), scan restarts at digit 0,
//    pending data discarded.
// CONFIGURATION
//  HEX_BLINK_EN defined: blink port exists and is double-buffered like dig_en; frame
//   counter 0..BLINK_FRM-1 advances at each frame boundary, toggles phase at wrap (phase=0
//   after reset). phase=1 forces digits with active blink[i]=1 dark (hex_on[i]=1, hex=7'h7F).
//  HEX_BLINK_EN undefined: no blink port, no frame counter; display never blinks.
// TESTING  (DIGITS=8, SCAN_DIV=4, BLANK_CYC=1, BLINK_FRM=2)
//  1 Hold rst 3 cycles, release -> hex=7'h7F, hex_on=8'hFF, frame_done=0 until cycle 31.
//  2 load data=32'h76543210, dig_en=8'hFF at cycle 0 -> from cycle 33: per slot 1 blank
//    cycle then hex_on=FE/hex=40, FD/79, FB/24, F7/30, EF/19, DF/12, BF/02, 7F/78.
//  3 Mid-frame load data=32'hFEDCBA98 -> current frame keeps old digits; next frame
//    digit0 hex=00, digit7 hex=0E; frame_done pulses once per 32 cycles exactly.
//  4 dig_en=8'h0F -> slots 4..7 hex_on=8'hFF, hex=7'h7F; slots 0..3 unchanged.
//  5 load coinciding with frame_done -> new data shown in the immediately following frame;
//    rst asserted mid-slot 5 -> outputs blank same cycle, scan restarts digit 0, display dark.
//  6 HEX_BLINK_EN, blink=8'h01 -> digit 0 dark in frames 2-3, 6-7..., lit in 0-1, 4-5;
//    digits 1..7 never dark; build without macro -> digit 0 never dark.

Source files
------------

// File: rtl/hex_scan_driver.sv
// rtl/hex_scan_driver.sv - time-multiplexed, double-buffered 7-segment scan driver.
// Optional blink feature enabled by defining HEX_BLINK_EN.
module hex_scan_driver #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2,
  parameter int BLINK_FRM = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dig_en,
  input  logic                  load,
`ifdef HEX_BLINK_EN
  input  logic [DIGITS-1:0]     blink,
`endif
  output logic [6:0]            hex,
  output logic [DIGITS-1:0]     hex_on,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   pend_data, act_data;
  logic [DIGITS-1:0]     pend_en, act_en;
  logic                  last_slot, boundary, lit;
  logic [3:0]            nib;

`ifdef HEX_BLINK_EN
  localparam int FW = (BLINK_FRM > 1) ? $clog2(BLINK_FRM) : 1;
  logic [DIGITS-1:0]     pend_blink, act_blink;
  logic [FW-1:0]         frm_cnt;
  logic                  phase;
`endif

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    last_slot = (presc == PW'(SCAN_DIV - 1));
    boundary  = last_slot && (idx == IW'(DIGITS - 1));
    nib       = act_data[{idx, 2'b00} +: 4];
    lit       = (presc >= PW'(BLANK_CYC)) && act_en[idx];
`ifdef HEX_BLINK_EN
    if (phase && act_blink[idx]) lit = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      pend_data  <= '0;
      pend_en    <= '0;
      act_data   <= '0;
      act_en     <= '0;
      hex        <= 7'h7F;
      hex_on     <= '1;
      frame_done <= 1'b0;
`ifdef HEX_BLINK_EN
      pend_blink <= '0;
      act_blink  <= '0;
      frm_cnt    <= '0;
      phase      <= 1'b0;
`endif
    end else begin
      frame_done <= boundary;

      if (last_slot) begin
        presc <= '0;
        idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end

      if (load) begin
        pend_data <= data;
        pend_en   <= dig_en;
      end

      // A load landing on the boundary bypasses pending so it shows next frame.
      if (boundary) begin
        act_data <= load ? data   : pend_data;
        act_en   <= load ? dig_en : pend_en;
      end

`ifdef HEX_BLINK_EN
      if (load) pend_blink <= blink;
      if (boundary) begin
        act_blink <= load ? blink : pend_blink;
        if (frm_cnt == FW'(BLINK_FRM - 1)) begin
          frm_cnt <= '0;
          phase   <= ~phase;
        end else begin
          frm_cnt <= frm_cnt + FW'(1);
        end
      end
`endif

      if (lit) begin
        hex_on <= ~(DIGITS'(1) << idx);
        hex    <= decode(nib);
      end else begin
        hex_on <= '1;
        hex    <= 7'h7F;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// tb/tb_hex_scan_driver.sv - scoreboard bench for hex_scan_driver (DIGITS=8, SCAN_DIV=4).
module tb_hex_scan_driver;
  localparam int D  = 8;
  localparam int S  = 4;
  localparam int B  = 1;
  localparam int BF = 2;
  localparam int FR = S * D;
`ifdef HEX_BLINK_EN
  localparam bit HAS_BLINK = 1'b1;
`else
  localparam bit HAS_BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic [7:0]  dig_en = '0;
  logic [7:0]  blink = '0;
  logic        load = 1'b0;
  logic [6:0]  hex;
  logic [7:0]  hex_on;
  logic        frame_done;

  hex_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .BLANK_CYC(B), .BLINK_FRM(BF)) dut (
    .clk(clk), .rst(rst), .data(data), .dig_en(dig_en), .load(load),
`ifdef HEX_BLINK_EN
    .blink(blink),
`endif
    .hex(hex), .hex_on(hex_on), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] hx;
    logic [7:0] on;
    logic       fd;
    logic [31:0] cyc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int c = 0;
  bit running = 1'b0;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0] pdata = '0, adata = '0;
  logic [7:0]  pen = '0, aen = '0, pbl = '0, abl = '0;

  // Expected outputs derived from the absolute cycle number since reset release.
  always @(posedge clk) begin
    if (running && !rst) begin : model
      int p, i, nb;
      bit ph, lt;
      exp_t e;
      p  = c % S;
      i  = (c / S) % D;
      nb = c / FR;
      ph = ((nb / BF) % 2) == 1;
      lt = (p >= B) && aen[i] && !(HAS_BLINK && ph && abl[i]);
      e.cyc = c;
      e.fd  = (c % FR) == FR - 1;
      e.on  = lt ? ~(8'd1 << i) : 8'hFF;
      e.hx  = lt ? seg_tab[adata[4*i +: 4]] : 7'h7F;
      q.push_back(e);
      if (load) begin
        pdata = data; pen = dig_en; pbl = blink;
      end
      if (e.fd) begin
        adata = pdata; aen = pen; abl = pbl;
      end
      c++;
    end
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin : cmp
      exp_t e;
      e = q.pop_front();
      total++;
      if (hex !== e.hx || hex_on !== e.on || frame_done !== e.fd) begin
        bad++;
        $display("FAIL scan cyc=%0d hex=%h exp=%h hex_on=%h exp=%h frame_done=%b exp=%b",
                 e.cyc, hex, e.hx, hex_on, e.on, frame_done, e.fd);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] en, input logic [7:0] bl);
    data = d; dig_en = en; blink = bl; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_phase(input int target);
    for (int k = 0; k < 2 * FR && (c % FR) != target; k++) @(negedge clk);
    total++;
    if ((c % FR) != target) begin
      bad++;
      $display("FAIL wait_phase cyc_mod=%0d exp=%0d", c % FR, target);
    end
  endtask

  task automatic release_rst();
    #1;
    rst = 1'b0;
    c = 0;
    running = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (hex !== 7'h7F) begin bad++; $display("FAIL reset_hex got=%h exp=7f", hex); end
    total++; if (hex_on !== 8'hFF) begin bad++; $display("FAIL reset_hex_on got=%h exp=ff", hex_on); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    release_rst();
  endtask

  task automatic test_basic();
    do_load(32'h76543210, 8'hFF, 8'h00);
    tick(2 * FR + 6);
  endtask

  task automatic test_midframe();
    wait_phase(10);
    do_load(32'hFEDCBA98, 8'hFF, 8'h00);
    tick(2 * FR);
  endtask

  task automatic test_dig_en();
    wait_phase(5);
    do_load(32'hFEDCBA98, 8'h0F, 8'h00);
    tick(2 * FR);
  endtask

  task automatic test_back_to_back();
    wait_phase(FR - 1);
    do_load(32'h13579BDF, 8'hFF, 8'h00);
    tick(FR + 8);
  endtask

  task automatic test_reset_mid_slot();
    wait_phase(22);
    #1;
    rst = 1'b1;
    running = 1'b0;
    q.delete();
    pdata = '0; adata = '0; pen = '0; aen = '0; pbl = '0; abl = '0;
    #1;
    total++; if (hex !== 7'h7F) begin bad++; $display("FAIL midrst_hex got=%h exp=7f", hex); end
    total++; if (hex_on !== 8'hFF) begin bad++; $display("FAIL midrst_hex_on got=%h exp=ff", hex_on); end
    tick(2);
    release_rst();
    tick(FR + 8);
  endtask

  task automatic test_blink();
    do_load(32'h76543210, 8'hFF, 8'h01);
    tick(8 * FR);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe();
    test_dig_en();
    test_back_to_back();
    test_reset_mid_slot();
    test_blink();
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
